// File: rtl/pulse_to_level_pkg.sv
// Shared types and helpers for the pulse-to-level converter and its counter.
package pulse_to_level_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int unsigned CNT_W_DEFAULT = 4;

  function automatic int unsigned pend_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam int unsigned PEND_MAX = pend_max(CNT_W_DEFAULT);

endpackage

// File: rtl/pulse_to_level_sat_counter.sv
// Up/down saturating counter with sticky overflow, reusable for score/move counts.
module sat_counter
  import pulse_to_level_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(pend_max(CNT_W));

  // Simultaneous inc and dec cancel, so a full counter never flags overflow then.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (inc && !dec) begin
      if (count == MAX) overflow <= 1'b1;
      else              count    <= count + 1'b1;
    end else if (dec && !inc && count != '0) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pulse_to_level.sv
// Turns one-cycle request pulses into held levels with a minimum hold,
// a mandatory low gap between intervals and an in-order pending queue.
module pulse_to_level
  import pulse_to_level_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int MIN_HOLD = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             pulse,
  input  logic             ack,
  input  logic             clear,
  output logic             q,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  localparam int HW = $clog2(MIN_HOLD + 1);

  state_t        state, state_nxt;
  logic [HW-1:0] hold_cnt;
  logic          launch_req, launch, hold_met, q_nxt, inc, dec;

  assign launch_req = (pending != '0 || pulse) && !clear;
  assign hold_met   = hold_cnt >= HW'(MIN_HOLD);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      q     <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    launch    = 1'b0;
    case (state)
      IDLE: if (launch_req) begin
        state_nxt = HOLD;
        launch    = 1'b1;
      end
      HOLD: state_nxt = (ack && hold_met) ? GAP : HOLD;
      GAP: if (launch_req) begin
        state_nxt = HOLD;
        launch    = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    q_nxt = (state_nxt == HOLD);
  end

  // Hold counter saturates at MIN_HOLD; early acks are simply not honoured.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                        hold_cnt <= '0;
    else if (launch)                    hold_cnt <= HW'(1);
    else if (state == HOLD && !hold_met) hold_cnt <= hold_cnt + 1'b1;
    else if (state != HOLD)             hold_cnt <= '0;
  end

  // A launch from an empty queue consumes the same-cycle pulse directly.
  assign inc = pulse && !clear && !(launch && pending == '0);
  assign dec = launch && pending != '0;

  sat_counter #(.CNT_W(CNT_W)) u_pend (
    .clock    (clock),
    .resetn   (resetn),
    .clear    (clear),
    .inc      (inc),
    .dec      (dec),
    .count    (pending),
    .overflow (overflow)
  );

endmodule
